// File: rtl/poly_uniform_eta_sampler.sv
// Rejection sampler: SHAKE256 bytes -> N coefficients in [-ETA, ETA].
// Each byte yields up to two nibble candidates, low nibble first.
module poly_uniform_eta_sampler #(
  parameter int N   = 256,
  parameter int ETA = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic [32*N-1:0] linear_a,
  output logic [8:0]      coef_cnt,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] BOUND = 4'(2 * ETA + 1);
  localparam logic [8:0] FULL  = 9'(N);

  state_t state_q, state_d;

  logic [8:0]         cnt_q, cnt_d;
  logic signed [31:0] coef_q [N];

  logic [3:0]         t0, t1;
  logic               acc0, acc1;
  logic               fire, room2;
  logic signed [31:0] v0, v1;
  logic               wa_en, wb_en;
  logic signed [31:0] wa_val, wb_val;
  logic [7:0]         wa_idx, wb_idx;

  assign t0    = in_data[3:0];
  assign t1    = in_data[7:4];
  assign acc0  = t0 < BOUND;
  assign acc1  = t1 < BOUND;
  assign v0    = 32'(ETA) - {28'd0, t0};
  assign v1    = 32'(ETA) - {28'd0, t1};
  assign room2 = cnt_q <= FULL - 9'd2;

  // start wins over a handshake in the same cycle
  assign fire  = (state_q == SAMPLE) && in_valid && !start;

  assign wa_en  = fire && (acc0 || acc1);
  assign wa_val = acc0 ? v0 : v1;
  assign wa_idx = cnt_q[7:0];
  assign wb_en  = fire && acc0 && acc1 && room2;
  assign wb_val = v1;
  assign wb_idx = cnt_q[7:0] + 8'd1;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = 9'd0;
    end else if (wb_en) begin
      cnt_d = cnt_q + 9'd2;
    end else if (wa_en) begin
      cnt_d = cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (start) state_d = SAMPLE;
      end
      state_q == SAMPLE: begin
        if (!start && cnt_d == FULL) state_d = DONE;
      end
      state_q == DONE: begin
        if (start) state_d = SAMPLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (1'b1)
      state_q == SAMPLE: in_ready = 1'b1;
      state_q == DONE:   done     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 9'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) coef_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wa_en && wa_idx == 8'(i)) begin
          coef_q[i] <= wa_val;
        end else if (wb_en && wb_idx == 8'(i)) begin
          coef_q[i] <= wb_val;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign linear_a[32*g +: 32] = coef_q[g];
  end

  assign coef_cnt = cnt_q;

endmodule
